data_memory_responder: RTL and testbench

- Memory-side responder for the CPU data port; serves one load or store at a time over a req/ack handshake.
- Configurable wait-state latency, byte-enable writes and range checking.
- Sits between the CPU's MemRead/MemWrite datapath and the word-addressed storage.
- Replaces the zero-latency combinational data memory, so the core can be tested against realistic stall behaviour.

---
 rtl/data_memory_responder.sv | 92 +++++++++
 tb/tb_data_memory_responder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: req/ack data memory with WAIT_CYCLES wait states, byte-enable stores and range checking.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned accesses and flag errors on err_o.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic        access, ok;
    logic [AW-1:0] idx;
    logic [31:0] mem [DEPTH_WORDS];
    assign idx = addr_q[AW+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
    logic err_q;
    assign ok    = (addr_q < 32'(DEPTH_WORDS * 4)) && (addr_q[1:0] == 2'b00);
    assign err_o = ack_o & err_q;
    always_ff @(posedge clk_i)
        if (rst_i)
            err_q <= 1'b0;
        else if (access)
            err_q <= !ok;
`else
    assign ok    = addr_q < 32'(DEPTH_WORDS * 4);
    assign err_o = 1'b0;
`endif
    assign ack_o   = state_q == RESP;
    assign busy_o  = state_q != IDLE;
    assign rdata_o = rdata_q;
    // A zero WAIT_CYCLES still passes through WAIT so the access edge is always one edge after acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        case (state_q)
            IDLE: if (req_i) begin
                state_d = WAIT;
                cnt_d   = 4'(WAIT_CYCLES);
            end
            WAIT: if (cnt_q == 4'd0) begin
                state_d = RESP;
                access  = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req_i) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                be_q    <= be_i;
            end
            if (access && !we_q)
                rdata_q <= ok ? mem[idx] : 32'd0;
        end
    end
    always_ff @(posedge clk_i)
        if (!rst_i && access && we_q && ok)
            for (int i = 0; i < 4; i++)
                if (be_q[i])
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed checks of a WAIT_CYCLES=2 instance and a zero-latency instance.
module tb_data_memory_responder;
    logic        clk = 1'b0, rst = 1'b1, req0 = 1'b0, req1 = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        ack0, busy0, err0, ack1, busy1, err1;
    logic [31:0] rdata0, rdata1, rd;
    logic        er;
    int          n_cmp = 0, n_bad = 0, acks;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic ALIGN = 1'b1;
`else
    localparam logic ALIGN = 1'b0;
`endif
    data_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .be_i(be), .ack_o(ack0), .rdata_o(rdata0), .busy_o(busy0), .err_o(err0));
    data_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .be_i(be), .ack_o(ack1), .rdata_o(rdata1), .busy_o(busy1), .err_o(err1));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic txn(input string tag, input bit sel, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input int exp_lat,
                       output logic [31:0] rdo, output logic ero);
        int lat;
        @(negedge clk);
        we = w; addr = a; wdata = d; be = b;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        lat = 0;
        while (!(sel ? ack1 : ack0) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        rdo = sel ? rdata1 : rdata0;
        ero = sel ? err1 : err0;
    endtask
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ack", ack0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_err", err0, 0);
        chk("rst_rdata", rdata0, 0);
        rst = 1'b0;
        txn("st10", 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3, rd, er);
        chk("st10_err", er, 0);
        txn("ld10", 0, 0, 32'h10, 0, 4'h0, 3, rd, er);
        chk("ld10_data", rd, 32'hDEADBEEF);
        chk("ld10_err", er, 0);
        @(negedge clk);
        chk("ack_pulse", ack0, 0);
        txn("st10b", 0, 1, 32'h10, 32'h000000AA, 4'h1, 3, rd, er);
        chk("st_hold_rdata", rd, 32'hDEADBEEF);
        txn("ld10b", 0, 0, 32'h10, 0, 4'hF, 3, rd, er);
        chk("partial", rd, 32'hDEADBEAA);
        txn("st10z", 0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 3, rd, er);
        txn("ld10z", 0, 0, 32'h10, 0, 4'h0, 3, rd, er);
        chk("be_zero", rd, 32'hDEADBEAA);
        txn("st20", 0, 1, 32'h20, 32'h11111111, 4'hF, 3, rd, er);
        // busy ignore: a stray store to 0x20 while the 0x40 store is in flight
        @(negedge clk);
        we = 1'b1; addr = 32'h40; wdata = 32'h00000055; be = 4'hF; req0 = 1'b1;
        @(negedge clk);
        addr = 32'h20; wdata = 32'hBADBAD00;
        chk("busy_high", busy0, 1);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req0 = 1'b0;
            if (ack0) acks++;
        end
        chk("busy_acks", acks, 1);
        txn("ld40", 0, 0, 32'h40, 0, 4'h0, 3, rd, er);
        chk("busy_capture", rd, 32'h00000055);
        txn("ld20", 0, 0, 32'h20, 0, 4'h0, 3, rd, er);
        chk("busy_ignored", rd, 32'h11111111);
        // reset one cycle after acceptance
        txn("st30", 0, 1, 32'h30, 32'hCAFEF00D, 4'hF, 3, rd, er);
        @(negedge clk);
        we = 1'b1; addr = 32'h30; wdata = 32'h12345678; be = 4'hF; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", busy0, 0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack0) acks++;
        end
        chk("rst_mid_acks", acks, 0);
        txn("ld30", 0, 0, 32'h30, 0, 4'h0, 3, rd, er);
        chk("rst_mid_data", rd, 32'hCAFEF00D);
        // reset on the access edge
        @(negedge clk);
        we = 1'b1; addr = 32'h30; wdata = 32'h0BADF00D; be = 4'hF; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_edge_ack", ack0, 0);
        txn("ld30b", 0, 0, 32'h30, 0, 4'h0, 3, rd, er);
        chk("rst_edge_data", rd, 32'hCAFEF00D);
        // out of range
        txn("ld400", 0, 0, 32'h400, 0, 4'h0, 3, rd, er);
        chk("oor_ld_data", rd, 0);
        chk("oor_ld_err", er, ALIGN);
        txn("st0", 0, 1, 32'h0, 32'h01020304, 4'hF, 3, rd, er);
        txn("st400", 0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 3, rd, er);
        chk("oor_st_err", er, ALIGN);
        txn("ld0", 0, 0, 32'h0, 0, 4'h0, 3, rd, er);
        chk("oor_st_drop", rd, 32'h01020304);
        // misaligned store
        txn("st12", 0, 1, 32'h12, 32'h77777777, 4'hF, 3, rd, er);
        chk("mis_err", er, ALIGN);
        txn("ld10c", 0, 0, 32'h10, 0, 4'h0, 3, rd, er);
        chk("mis_word", rd, ALIGN ? 32'hDEADBEAA : 32'h77777777);
        // zero-latency instance
        txn("z_st8", 1, 1, 32'h8, 32'hA5A5A5A5, 4'hF, 1, rd, er);
        txn("z_ld8", 1, 0, 32'h8, 0, 4'h0, 1, rd, er);
        chk("z_data", rd, 32'hA5A5A5A5);
        @(negedge clk);
        chk("z_ack_pulse", ack1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
